// File: rtl/cbd_poly_writer.sv
// cbd_poly_writer: latches one 256-coefficient CBD polynomial, maps each
// signed coefficient to its canonical residue mod Q and streams LANES
// residues per beat into the polynomial BRAM, honouring wr_ready_i.
// Optional build macro CBD_RANGE_CHECK_EN adds a sticky [-3,3] range check
// on accepted coefficients (err_o); without it err_o is tied low.
module cbd_poly_writer #(
    parameter  int unsigned LANES  = 2,
    parameter  int unsigned IDX_W  = 3,
    parameter  int unsigned Q      = 3329,
    localparam int unsigned BEAT_W = $clog2(256 / LANES)
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [255:0][7:0]       poly_i,
    input  logic [IDX_W-1:0]        idx_i,
    output logic                    wr_en_o,
    input  logic                    wr_ready_i,
    output logic [IDX_W+BEAT_W-1:0] wr_addr_o,
    output logic [12*LANES-1:0]     wr_data_o,
    output logic                    done_o,
    output logic                    err_o
);

    localparam int unsigned       NBEATS    = 256 / LANES;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);
    localparam logic [12:0]       Q13       = 13'(Q);

    typedef enum logic {
        IDLE,
        DRAIN
    } state_e;

    state_e              state_q, state_d;
    logic [255:0][7:0]   poly_q, poly_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                done_q, done_d;
    logic [12*LANES-1:0] lane_data;

    // Sign-extend to 13 bits and add Q for negative values; no wrap is
    // possible for any 8-bit input.
    function automatic logic [11:0] to_residue(input logic [7:0] v);
        logic [12:0] ext;
        logic [12:0] sum;
        ext = {{5{v[7]}}, v};
        sum = v[7] ? (ext + Q13) : ext;
        return sum[11:0];
    endfunction

    // Residues of the coefficients addressed by the current beat.
    always_comb begin
        lane_data = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            lane_data[12*l +: 12] =
                to_residue(poly_q[8'(32'(beat_q) * 32'(LANES) + 32'(l))]);
        end
    end

    // State, latched polynomial and beat counter registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            poly_q  <= '0;
            idx_q   <= '0;
            beat_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            poly_q  <= poly_d;
            idx_q   <= idx_d;
            beat_q  <= beat_d;
            done_q  <= done_d;
        end
    end

    // Next-state and output decode; write outputs are forced to zero
    // outside DRAIN so that reset mid-drain clears them immediately.
    always_comb begin
        state_d   = state_q;
        poly_d    = poly_q;
        idx_d     = idx_q;
        beat_d    = beat_q;
        done_d    = 1'b0;
        ready_o   = 1'b0;
        wr_en_o   = 1'b0;
        wr_addr_o = '0;
        wr_data_o = '0;
        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    poly_d  = poly_i;
                    idx_d   = idx_i;
                    beat_d  = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                wr_en_o   = 1'b1;
                wr_addr_o = {idx_q, beat_q};
                wr_data_o = lane_data;
                if (wr_ready_i) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign done_o = done_q;

`ifdef CBD_RANGE_CHECK_EN
    logic range_bad;
    logic err_q;

    // Flag any incoming coefficient outside [-3,3].
    always_comb begin
        range_bad = 1'b0;
        for (int unsigned n = 0; n < 256; n++) begin
            if ($signed(poly_i[n]) > 8'sd3 || $signed(poly_i[n]) < -8'sd3) begin
                range_bad = 1'b1;
            end
        end
    end

    // Sticky error, captured only on an accepted polynomial.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_q <= 1'b0;
        end else if (state_q == IDLE && valid_i && range_bad) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_cbd_poly_writer.sv
// Self-checking bench for cbd_poly_writer (LANES=2, IDX_W=3).
module tb_cbd_poly_writer;

    localparam int LANES = 2;
    localparam int IDX_W = 3;
    localparam int NB    = 256 / LANES;
    localparam int BW    = $clog2(NB);

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   valid = 1'b0;
    logic                   ready;
    logic [255:0][7:0]      poly = '0;
    logic [IDX_W-1:0]       idx = '0;
    logic                   wr_en;
    logic                   wr_ready = 1'b1;
    logic [IDX_W+BW-1:0]    addr;
    logic [12*LANES-1:0]    data;
    logic                   done;
    logic                   err;

    int total = 0;
    int bad   = 0;
    bit err_exp = 1'b0;

    logic [11:0] mem [0:(1<<IDX_W)-1][0:255];

    always #5 clk = ~clk;

    cbd_poly_writer #(
        .LANES(LANES),
        .IDX_W(IDX_W),
        .Q(3329)
    ) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .valid_i(valid),
        .ready_o(ready),
        .poly_i(poly),
        .idx_i(idx),
        .wr_en_o(wr_en),
        .wr_ready_i(wr_ready),
        .wr_addr_o(addr),
        .wr_data_o(data),
        .done_o(done),
        .err_o(err)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1);
    end

    // Canonical residue of a signed byte: negative values map to Q+v.
    function automatic logic [11:0] residue(input logic [7:0] c);
        int v;
        v = $signed(c);
        if (v < 0) return 12'(3329 + v);
        return 12'(v);
    endfunction

    function automatic logic [12*LANES-1:0] beat_data(input logic [255:0][7:0] p, input int b);
        logic [12*LANES-1:0] r;
        r = '0;
        for (int l = 0; l < LANES; l++) r[12*l +: 12] = residue(p[b*LANES + l]);
        return r;
    endfunction

    function automatic bit out_of_range(input logic [255:0][7:0] p);
        for (int n = 0; n < 256; n++) begin
            int v;
            v = $signed(p[n]);
            if (v > 3 || v < -3) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [255:0][7:0] small_poly();
        logic [255:0][7:0] p;
        for (int n = 0; n < 256; n++) p[n] = 8'(int'($urandom_range(0, 6)) - 3);
        return p;
    endfunction

    function automatic logic [255:0][7:0] pattern_poly();
        logic [255:0][7:0] p;
        for (int n = 0; n < 256; n++) p[n] = 8'((n % 7) - 3);
        return p;
    endfunction

    task automatic note_accept(input logic [255:0][7:0] p);
`ifdef CBD_RANGE_CHECK_EN
        if (out_of_range(p)) err_exp = 1'b1;
`endif
    endtask

    // Present a polynomial while ready_o is high; returns just after the accept edge.
    task automatic start_poly(input logic [255:0][7:0] p, input logic [IDX_W-1:0] id);
        @(negedge clk);
        total++;
        if (ready !== 1'b1) begin
            $display("FAIL accept_ready: ready_o=%b required 1", ready);
            bad++;
        end
        valid = 1'b1;
        poly  = p;
        idx   = id;
        @(posedge clk);
        note_accept(p);
    endtask

    // Follow one polynomial from the cycle after accept to the done_o cycle.
    task automatic drain(input logic [255:0][7:0] p, input logic [IDX_W-1:0] id,
                         input int stall_beat, input int stall_len,
                         input bit nxt_valid, input logic [255:0][7:0] nxt_p,
                         input logic [IDX_W-1:0] nxt_id);
        int b   = 0;
        int cyc = 0;
        int st  = 0;
        while (b < NB && cyc < 4 * NB) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                valid = nxt_valid;
                poly  = nxt_p;
                idx   = nxt_id;
                total++;
                if (err !== err_exp) begin
                    $display("FAIL err_after_accept: err_o=%b required %b", err, err_exp);
                    bad++;
                end
            end
            total++;
            if (wr_en !== 1'b1 || ready !== 1'b0 || done !== 1'b0) begin
                $display("FAIL drain_ctrl beat %0d: wr_en=%b ready=%b done=%b required 1 0 0",
                         b, wr_en, ready, done);
                bad++;
            end
            total++;
            if (addr !== {id, BW'(b)}) begin
                $display("FAIL addr beat %0d: got %0d required %0d", b, addr, {id, BW'(b)});
                bad++;
            end
            total++;
            if (data !== beat_data(p, b)) begin
                $display("FAIL data beat %0d: got %h required %h", b, data, beat_data(p, b));
                bad++;
            end
            if (b == stall_beat && st < stall_len) begin
                wr_ready = 1'b0;
                st++;
            end else begin
                wr_ready = 1'b1;
                if (wr_en === 1'b1)
                    for (int l = 0; l < LANES; l++) mem[id][b*LANES + l] = data[12*l +: 12];
                b++;
            end
        end
        @(negedge clk);
        wr_ready = 1'b1;
        total++;
        if (done !== 1'b1 || ready !== 1'b1 || wr_en !== 1'b0) begin
            $display("FAIL done_cycle idx %0d: done=%b ready=%b wr_en=%b required 1 1 0",
                     id, done, ready, wr_en);
            bad++;
        end
    endtask

    task automatic check_mem(input logic [IDX_W-1:0] id, input logic [255:0][7:0] p);
        int miss = 0;
        for (int n = 0; n < 256; n++) if (mem[id][n] !== residue(p[n])) miss++;
        total++;
        if (miss != 0) begin
            $display("FAIL mem_contents idx %0d: %0d wrong entries required 0", id, miss);
            bad++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        total++;
        if (ready !== 1'b1 || wr_en !== 1'b0 || addr !== '0 || data !== '0 ||
            done !== 1'b0 || err !== 1'b0) begin
            $display("FAIL %s: ready=%b wr_en=%b addr=%0d data=%h done=%b err=%b required 1 0 0 0 0 0",
                     tag, ready, wr_en, addr, data, done, err);
            bad++;
        end
    endtask

    task automatic test_reset();
        #1;
        check_reset_outputs("reset_asserted");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset_released");
    endtask

    task automatic test_pattern();
        logic [255:0][7:0] p;
        p = pattern_poly();
        start_poly(p, 3'd5);
        drain(p, 3'd5, -1, 0, 1'b0, p, 3'd5);
        check_mem(3'd5, p);
    endtask

    task automatic test_stall();
        logic [255:0][7:0] p;
        p = pattern_poly();
        for (int n = 0; n < 256; n++) mem[5][n] = 12'hfff;
        start_poly(p, 3'd5);
        drain(p, 3'd5, 10, 3, 1'b0, p, 3'd5);
        check_mem(3'd5, p);
    endtask

    task automatic test_back_to_back();
        logic [255:0][7:0] p0, p1;
        p0 = small_poly();
        p1 = small_poly();
        start_poly(p0, 3'd0);
        drain(p0, 3'd0, -1, 0, 1'b1, p1, 3'd1);
        @(posedge clk);
        note_accept(p1);
        drain(p1, 3'd1, -1, 0, 1'b0, p1, 3'd1);
        check_mem(3'd0, p0);
        check_mem(3'd1, p1);
    endtask

    task automatic test_reset_mid_drain();
        logic [255:0][7:0] p;
        p = small_poly();
        start_poly(p, 3'd2);
        for (int k = 0; k <= 50; k++) begin
            @(negedge clk);
            valid = 1'b0;
            total++;
            if (addr !== {3'd2, BW'(k)}) begin
                $display("FAIL pre_reset_addr beat %0d: got %0d required %0d", k, addr, {3'd2, BW'(k)});
                bad++;
            end
        end
        rst_n = 1'b0;
        #1;
        err_exp = 1'b0;
        check_reset_outputs("reset_mid_drain");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (done !== 1'b0 || wr_en !== 1'b0 || ready !== 1'b1) begin
                $display("FAIL post_reset_idle: done=%b wr_en=%b ready=%b required 0 0 1", done, wr_en, ready);
                bad++;
            end
        end
        p = small_poly();
        start_poly(p, 3'd2);
        drain(p, 3'd2, -1, 0, 1'b0, p, 3'd2);
        check_mem(3'd2, p);
    endtask

    task automatic test_range_err();
        logic [255:0][7:0] p;
        p = small_poly();
        p[200] = 8'd4;
        start_poly(p, 3'd6);
        drain(p, 3'd6, -1, 0, 1'b0, p, 3'd6);
        p = small_poly();
        start_poly(p, 3'd7);
        drain(p, 3'd7, -1, 0, 1'b0, p, 3'd7);
        total++;
        if (err !== err_exp) begin
            $display("FAIL err_sticky: err_o=%b required %b", err, err_exp);
            bad++;
        end
    endtask

    task automatic test_extremes();
        logic [255:0][7:0] p;
        for (int n = 0; n < 256; n++) p[n] = 8'hfd;
        start_poly(p, 3'd3);
        drain(p, 3'd3, -1, 0, 1'b0, p, 3'd3);
        check_mem(3'd3, p);
        for (int n = 0; n < 256; n++) p[n] = 8'd3;
        start_poly(p, 3'd4);
        drain(p, 3'd4, -1, 0, 1'b0, p, 3'd4);
        check_mem(3'd4, p);
    endtask

    task automatic test_random();
        logic [255:0][7:0] p;
        logic [IDX_W-1:0] id;
        for (int t = 0; t < 4; t++) begin
            for (int n = 0; n < 256; n++) p[n] = 8'($urandom);
            id = IDX_W'($urandom);
            start_poly(p, id);
            drain(p, id, int'($urandom_range(0, NB - 1)), int'($urandom_range(0, 3)), 1'b0, p, id);
            check_mem(id, p);
        end
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_stall();
        test_back_to_back();
        test_reset_mid_drain();
        test_range_err();
        test_extremes();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
